// File: rtl/msi_bus_pkg.sv
// msi_bus_pkg: shared bus command/state encodings for the MSI snooping bus arbiter
package msi_bus_pkg;
  typedef enum logic [1:0] {BUS_RD, BUS_RDX, BUS_UPGR, BUS_FLUSH} bus_cmd_e;
  typedef enum logic [1:0] {IDLE, SNOOP, MEM, DONE} arb_state_e;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot round-robin pick, searching upward from the index after last_i
module rr_arbiter #(
  parameter int N  = 2,
  parameter int SW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [SW-1:0] last_i,
  output logic [N-1:0]  gnt_o
);
  // Walk offsets from farthest to nearest so the closest requester overwrites the rest
  always_comb begin
    gnt_o = '0;
    for (int i = N; i >= 1; i--)
      if (req_i[(int'(last_i) + i) % N]) gnt_o = N'(1) << ((int'(last_i) + i) % N);
  end
endmodule

// File: rtl/msi_bus_arbiter.sv
// msi_bus_arbiter: serialises MSI bus transactions: round-robin grant, snoop broadcast,
// optional cache-to-cache supply with writeback, memory access, completion pulse
module msi_bus_arbiter
  import msi_bus_pkg::*;
#(
  parameter int NUM_CACHES    = 2,
  parameter int AWIDTH        = 9,
  parameter int DWIDTH        = 32,
  parameter int SNOOP_TIMEOUT = 15,
  localparam int SW = idx_w(NUM_CACHES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_CACHES-1:0]        req,
  input  logic [2*NUM_CACHES-1:0]      req_cmd,
  input  logic [AWIDTH*NUM_CACHES-1:0] req_addr,
  input  logic [DWIDTH*NUM_CACHES-1:0] req_wdata,
  output logic [NUM_CACHES-1:0]        gnt,
  output logic [NUM_CACHES-1:0]        done,
  output logic [DWIDTH-1:0]            rdata,
  output logic                         rshared,
  output logic                         snoop_err,
  output logic                         snoop_valid,
  output logic [1:0]                   snoop_cmd,
  output logic [AWIDTH-1:0]            snoop_addr,
  output logic [SW-1:0]                snoop_src,
  input  logic [NUM_CACHES-1:0]        snoop_ack,
  input  logic [NUM_CACHES-1:0]        snoop_hit,
  input  logic [NUM_CACHES-1:0]        snoop_supply,
  input  logic [DWIDTH*NUM_CACHES-1:0] snoop_data,
  output logic                         mem_rd,
  output logic                         mem_wr,
  output logic [AWIDTH-1:0]            mem_addr,
  output logic [DWIDTH-1:0]            mem_wdata,
  input  logic [DWIDTH-1:0]            mem_rdata,
  input  logic                         mem_ready
);
  localparam int CW = $clog2(SNOOP_TIMEOUT + 1);
  arb_state_e state_q, state_d;
  bus_cmd_e cmd_q;
  logic [NUM_CACHES-1:0] gnt_q, win, hits, sups;
  logic [SW-1:0] last_q, src;
  logic [1:0] cmd_n;
  logic [AWIDTH-1:0] addr_q, addr_n;
  logic [DWIDTH-1:0] wdata_q, wdata_n, rdata_q, sup_data;
  logic [CW-1:0] cnt_q;
  logic rshared_q, err_q, we_q, all_ack, has_sup, snoop_exit, is_snoop, is_mem;

  rr_arbiter #(.N(NUM_CACHES), .SW(SW)) u_rr (.req_i(req), .last_i(last_q), .gnt_o(win));

  // The requester's own response lines are ignored; unacked caches count as miss
  assign all_ack    = &(snoop_ack | gnt_q);
  assign hits       = snoop_hit & snoop_ack & ~gnt_q;
  assign sups       = snoop_supply & snoop_ack & ~gnt_q;
  assign is_snoop   = state_q == SNOOP;
  assign is_mem     = state_q == MEM;
  assign snoop_exit = is_snoop && (all_ack || cnt_q == CW'(SNOOP_TIMEOUT - 1));

  // Descending scan: the lowest-index supplier is the last one written
  always_comb begin
    src      = '0;
    cmd_n    = '0;
    addr_n   = '0;
    wdata_n  = '0;
    sup_data = '0;
    has_sup  = 1'b0;
    for (int i = NUM_CACHES - 1; i >= 0; i--) begin
      if (gnt_q[i]) src = SW'(i);
      if (win[i]) begin
        cmd_n   = req_cmd[2*i +: 2];
        addr_n  = req_addr[AWIDTH*i +: AWIDTH];
        wdata_n = req_wdata[DWIDTH*i +: DWIDTH];
      end
      if (sups[i]) begin
        sup_data = snoop_data[DWIDTH*i +: DWIDTH];
        has_sup  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = |req ? SNOOP : IDLE;
      SNOOP: if (snoop_exit)
               state_d = (cmd_q == BUS_UPGR || (cmd_q == BUS_RDX && has_sup)) ? DONE : MEM;
      MEM:   state_d = mem_ready ? DONE : MEM;
      DONE:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      gnt_q     <= '0;
      last_q    <= SW'(NUM_CACHES - 1);
      cmd_q     <= BUS_RD;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      rshared_q <= 1'b0;
      err_q     <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      err_q <= snoop_exit && !all_ack;
      if (state_q == IDLE && |req) begin
        gnt_q   <= win;
        cmd_q   <= bus_cmd_e'(cmd_n);
        addr_q  <= addr_n;
        wdata_q <= wdata_n;
        cnt_q   <= '0;
      end
      if (is_snoop) cnt_q <= snoop_exit ? '0 : cnt_q + 1'b1;
      // A supplied BusRd line is written back so memory matches the now-Shared copy
      if (snoop_exit) begin
        rshared_q <= |hits;
        we_q      <= cmd_q == BUS_FLUSH || (cmd_q == BUS_RD && has_sup);
        if (has_sup && (cmd_q == BUS_RD || cmd_q == BUS_RDX)) begin
          rdata_q <= sup_data;
          if (cmd_q == BUS_RD) wdata_q <= sup_data;
        end
      end
      if (is_mem && mem_ready && !we_q) rdata_q <= mem_rdata;
      if (state_q == DONE) begin
        gnt_q  <= '0;
        last_q <= src;
      end
    end

  always_comb begin
    gnt         = gnt_q;
    done        = state_q == DONE ? gnt_q : '0;
    rdata       = rdata_q;
    rshared     = rshared_q;
    snoop_err   = err_q;
    snoop_valid = is_snoop;
    snoop_cmd   = is_snoop ? cmd_q : 2'b00;
    snoop_addr  = is_snoop ? addr_q : '0;
    snoop_src   = is_snoop ? src : '0;
    mem_rd      = is_mem && !we_q;
    mem_wr      = is_mem && we_q;
    mem_addr    = is_mem ? addr_q : '0;
    mem_wdata   = (is_mem && we_q) ? wdata_q : '0;
  end
endmodule
